// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add per clock, LSB first, registered carry.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    // Two half-adder stages with their carries ORed; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        logic hs;
        hs = x ^ y;
        return {(x & y) | (c & hs), hs ^ c};
    endfunction

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic             cout_r;
    logic [CNT_W-1:0] count;
    logic [1:0]       fa;

    assign fa = full_add(ra[0], rb[0], carry);

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;
    assign ovf = ovf_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            sum_r  <= '0;
            carry  <= 1'b0;
            cout_r <= 1'b0;
            count  <= '0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        count <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    sum_r <= {fa[0], sum_r[WIDTH-1:1]};
                    carry <= fa[1];
                    // Counter holds at LAST instead of wrapping; the state change ends the run.
                    if (count == LAST) begin
                        cout_r <= fa[1];
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_r  <= carry ^ fa[1];
`endif
                        state  <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT) || (state == DONE);
    assign done = (state == DONE);
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8), checked with immediate assertions.
// Define SERIAL_ADDER_OVF_EN to also exercise the overflow output.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int total  = 0;
    int passed = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after edge E<from>; runs to the edge after DONE and checks the result.
    task automatic finish_op(input string tag, input int from, input bit scramble,
                             input logic [W-1:0] exp_sum, input logic exp_cout,
                             input logic exp_ovf);
        logic early;
        early = 1'b0;
        for (int k = from + 1; k <= W - 1; k++) begin
            if (scramble) begin
                a   = W'($urandom);
                b   = W'($urandom);
                cin = 1'($urandom);
            end
            tick();
            if (done || !busy) early = 1'b1;
        end
        chk({tag, "_no_early_done"}, {63'd0, early}, 64'd0);
        tick();
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_busy_in_done"}, {63'd0, busy}, 64'd1);
        chk({tag, "_sum"}, {56'd0, sum}, {56'd0, exp_sum});
        chk({tag, "_cout"}, {63'd0, cout}, {63'd0, exp_cout});
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, {63'd0, ovf}, {63'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf expectation");
`endif
        tick();
        chk({tag, "_done_pulse_one"}, {63'd0, done}, 64'd0);
        chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
        chk({tag, "_sum_held"}, {56'd0, sum}, {56'd0, exp_sum});
    endtask

    task automatic do_add(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic vc, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_e0"}, {63'd0, busy}, 64'd1);
        chk({tag, "_nodone_e0"}, {63'd0, done}, 64'd0);
        finish_op(tag, 0, 1'b0, exp_sum, exp_cout, exp_ovf);
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_sum", {56'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_add("add_35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
        tick();
        chk("idle_hold_sum", {56'd0, sum}, 64'h7F);
        chk("idle_hold_busy", {63'd0, busy}, 64'd0);

        do_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        do_add("add_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        do_add("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        do_add("ovf_80_ff", 8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1);
        do_add("ovf_10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // Start ignored while busy, including the DONE cycle.
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        finish_op("busy_ignore", 2, 1'b0, 8'hFF, 1'b0, 1'b0);
        tick();
        chk("restart_at_idle", {63'd0, busy}, 64'd1);
        start = 1'b0;
        finish_op("restart_result", 0, 1'b0, 8'h02, 1'b0, 1'b0);

        // Asynchronous reset mid-operation.
        a     = 8'hF0;
        b     = 8'h0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_sum", {56'd0, sum}, 64'd0);
        chk("arst_cout", {63'd0, cout}, 64'd0);
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        chk("arst_no_done", {63'd0, saw_done}, 64'd0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle", {63'd0, busy}, 64'd0);
        do_add("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // Operands change every cycle after E0.
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_op("scramble", 0, 1'b1, 8'h46, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a half-adder pair plus a carry flip-flop. It consumes two parallel operands, adds one bit per clock LSB-first, and returns a parallel sum and carry-out.
- Sits directly downstream of the half-adder cells. It is the sequential consumer that chains their S/C outputs through a registered carry.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry-out of the MSB; held with sum.

Behaviour:
- Reset: rst_n low asynchronously forces the following, regardless of state:
  - state=IDLE, busy=0, done=0, sum=0, cout=0;
  - internal shift registers, carry flop and bit counter = 0.
- Reset mid-operation aborts the addition. No done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads a->ra, b->rb, cin->carry, count=0, and moves to SHIFT. This edge is E0.
  - start=0 stays in IDLE; sum and cout hold their values.
- SHIFT, once per edge:
  - s = ra[0]^rb[0]^carry, carry = (ra[0]&rb[0]) | (carry&(ra[0]^rb[0])). This is two half-adder stages with an OR on the carries.
  - ra and rb shift right by 1. s shifts into the sum register at the MSB, and the sum register shifts right.
  - count increments.
  - At the edge where count==WIDTH-1, the final bit is processed, cout is loaded with the new carry, and the state moves to DONE.
  - SHIFT therefore occupies edges E1..E_WIDTH.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE on the next edge.
- Outputs: busy=1 in SHIFT and DONE; done=1 only in DONE.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH+1 cycles after start was sampled.
- Sum register visibility: it is updated in place during SHIFT, so partial values are visible on sum while busy. sum is only valid when done=1 or in IDLE after a completed operation.
- start while busy (SHIFT or DONE) is ignored. It is not queued.
- Earliest back-to-back start: start high in the DONE cycle is ignored. The next accepted start is at the first IDLE edge, giving a throughput of one addition per WIDTH+2 cycles.
- Operand changes on a, b or cin after E0 have no effect on the current operation.
- Arithmetic is unsigned modulo 2^WIDTH, with cout as bit WIDTH of the full sum.
- Counter width: clog2(WIDTH) bits, compared against the constant WIDTH-1. It never wraps beyond that value.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit) = signed two's-complement overflow, computed as the carry into the MSB XOR the carry out of the MSB.
  - ovf is captured at the same edge as cout and held with sum.
  - ovf resets to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, cin=0, start pulsed one cycle -> busy high from E0; done high exactly in the cycle after E8; sum=0x7F, cout=0; sum held in IDLE afterwards.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0, confirming carry-in is used.
- With SERIAL_ADDER_OVF_EN defined:
  - a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1;
  - a=0x80, b=0xFF -> sum=0x7F, cout=1, ovf=1;
  - a=0x10, b=0x20 -> ovf=0.
- Start a=0xAA, b=0x55; assert start again at E3 with a=0x01, b=0x01; also hold start high through the DONE cycle -> second request is ignored; result sum=0xFF, cout=0; the next operation begins only at the first IDLE edge.
- Start a=0xF0, b=0x0F, then drop rst_n at E4 (asynchronously, mid-cycle) -> outputs immediately 0, busy=0, no done pulse. Release reset, then start a=0x01, b=0x02 -> sum=0x03 after the normal latency.
- Change a and b every cycle during SHIFT after starting with a=0x12, b=0x34 -> result still sum=0x46, cout=0.
